// File: rtl/apbcc_update_issuer_pkg.sv
// Shared types and defaults for the ApBCC update issuer.
// Entry layout and queue sizing used by the writer-side queue.
package ApbccUpdateTypes;

   localparam int APBCC_ADDR_WIDTH         = 32;
   localparam int APBCC_UPDATE_QUEUE_DEPTH = 8;
   localparam int APBCC_PTR_WIDTH          = $clog2(APBCC_UPDATE_QUEUE_DEPTH);

   typedef logic [APBCC_ADDR_WIDTH-1:0] ApbccAddrPath;
   typedef logic [APBCC_PTR_WIDTH-1:0]  ApbccQueuePtrPath;
   typedef logic [APBCC_PTR_WIDTH:0]    ApbccQueueCountPath;

   typedef struct packed {
      ApbccAddrPath brAddr;
      ApbccAddrPath nextAddr;
      logic         isCondBr;
   } ApbccUpdateEntry;

endpackage

// File: rtl/apbcc_update_issuer_ptr.sv
// Head/tail/occupancy tracking for a circular queue with
// multiple pushes and pops per cycle.
module apbcc_multi_queue_pointer #(
   parameter int DEPTH    = 8,
   parameter int PUSH_MAX = 2,
   parameter int POP_MAX  = 2,
   parameter int PTR_W    = $clog2(DEPTH),
   parameter int CNT_W    = $clog2(DEPTH) + 1,
   parameter int PUSH_W   = $clog2(PUSH_MAX + 1),
   parameter int POP_W    = $clog2(POP_MAX + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PUSH_W-1:0] i_push_cnt,
   input  logic [POP_W-1:0]  i_pop_cnt,
   output logic [PTR_W-1:0]  o_head,
   output logic [PTR_W-1:0]  o_tail,
   output logic [CNT_W-1:0]  o_occupancy
);

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_occ;

   // Power-of-two depth: pointer overflow is the wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
      end else begin
         r_head <= r_head + PTR_W'(i_pop_cnt);
         r_tail <= r_tail + PTR_W'(i_push_cnt);
         r_occ  <= r_occ + CNT_W'(i_push_cnt) - CNT_W'(i_pop_cnt);
      end
   end

   assign o_head      = r_head;
   assign o_tail      = r_tail;
   assign o_occupancy = r_occ;

endmodule

// File: rtl/apbcc_update_issuer.sv
// Coalescing update queue feeding resolved ApBCC branch results
// to the approximate-BCC target buffer write ports.
module apbcc_update_issuer
   import ApbccUpdateTypes::*;
#(
   parameter int LANE_NUM    = 2,
   parameter int OUT_NUM     = 2,
   parameter int QUEUE_DEPTH = APBCC_UPDATE_QUEUE_DEPTH,
   parameter int ADDR_WIDTH  = APBCC_ADDR_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [LANE_NUM-1:0]              in_valid,
   input  logic [LANE_NUM-1:0]              in_is_apbcc,
   input  logic [LANE_NUM*ADDR_WIDTH-1:0]   in_br_addr,
   input  logic [LANE_NUM*ADDR_WIDTH-1:0]   in_next_addr,
   input  logic [LANE_NUM-1:0]              in_is_cond_br,
   output logic                             in_ready,
   output logic [OUT_NUM-1:0]               upd_valid,
   output logic [OUT_NUM*ADDR_WIDTH-1:0]    upd_br_addr,
   output logic [OUT_NUM*ADDR_WIDTH-1:0]    upd_next_addr,
   output logic [OUT_NUM-1:0]               upd_is_cond_br,
   input  logic [OUT_NUM-1:0]               upd_ack,
   output logic [$clog2(QUEUE_DEPTH):0]     occupancy,
   output logic [15:0]                      drop_count
);

   localparam int PW  = $clog2(QUEUE_DEPTH);
   localparam int CW  = PW + 1;
   localparam int LCW = $clog2(LANE_NUM + 1);
   localparam int OCW = $clog2(OUT_NUM + 1);

   ApbccUpdateEntry     r_ent   [QUEUE_DEPTH];
   ApbccUpdateEntry     w_ent_n [QUEUE_DEPTH];
   logic [QUEUE_DEPTH-1:0] r_val;
   logic [QUEUE_DEPTH-1:0] w_val_n;
   logic [15:0]         r_drop;
   logic [16:0]         w_drop_sum;

   logic [PW-1:0]       w_head;
   logic [PW-1:0]       w_tail;
   logic [CW-1:0]       w_occ;
   logic [LCW-1:0]      w_push_cnt;
   logic [LCW-1:0]      w_drop_cnt;
   logic [OCW-1:0]      w_pop_cnt;
   logic [LANE_NUM-1:0] w_lane_act;
   logic                w_run;
   logic                w_hit;
   logic [PW-1:0]       w_idx;

   apbcc_multi_queue_pointer #(
      .DEPTH    (QUEUE_DEPTH),
      .PUSH_MAX (LANE_NUM),
      .POP_MAX  (OUT_NUM)
   ) u_ptr (
      .clk         (clk),
      .rst         (rst),
      .i_push_cnt  (w_push_cnt),
      .i_pop_cnt   (w_pop_cnt),
      .o_head      (w_head),
      .o_tail      (w_tail),
      .o_occupancy (w_occ)
   );

   assign w_lane_act = rst ? '0 : (in_valid & in_is_apbcc);
   // Start-of-cycle occupancy only; same-cycle pops are not credited.
   assign in_ready   = !rst && (w_occ <= CW'(QUEUE_DEPTH - LANE_NUM));
   assign occupancy  = w_occ;
   assign drop_count = r_drop;

   for (genvar g = 0; g < OUT_NUM; g++) begin : g_slot
      logic [PW-1:0] w_slot;
      assign w_slot = w_head + PW'(g);
      assign upd_valid[g] = !rst && (w_occ > CW'(g));
      assign upd_br_addr[g*ADDR_WIDTH +: ADDR_WIDTH]   = r_ent[w_slot].brAddr;
      assign upd_next_addr[g*ADDR_WIDTH +: ADDR_WIDTH] = r_ent[w_slot].nextAddr;
      assign upd_is_cond_br[g] = r_ent[w_slot].isCondBr;
   end

   always_comb begin
      w_pop_cnt = '0;
      w_run     = 1'b1;
      for (int i = 0; i < OUT_NUM; i++) begin
         w_run = w_run & upd_valid[i] & upd_ack[i];
         if (w_run) w_pop_cnt = w_pop_cnt + OCW'(1);
      end
   end

   // Popped entries leave first so a late match allocates a new slot.
   always_comb begin
      w_ent_n    = r_ent;
      w_val_n    = r_val;
      w_push_cnt = '0;
      w_drop_cnt = '0;
      w_hit      = 1'b0;
      w_idx      = '0;
      for (int j = 0; j < OUT_NUM; j++) begin
         if (j < int'(w_pop_cnt)) w_val_n[w_head + PW'(j)] = 1'b0;
      end
      for (int i = 0; i < LANE_NUM; i++) begin
         w_hit = 1'b0;
         w_idx = '0;
         if (w_lane_act[i]) begin
            for (int k = 0; k < QUEUE_DEPTH; k++) begin
               if (w_val_n[k] &&
                   w_ent_n[k].brAddr == in_br_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                  w_hit = 1'b1;
                  w_idx = PW'(k);
               end
            end
            if (in_ready) begin
               if (!w_hit) begin
                  w_idx          = w_tail + PW'(w_push_cnt);
                  w_push_cnt     = w_push_cnt + LCW'(1);
                  w_val_n[w_idx] = 1'b1;
               end
               w_ent_n[w_idx] = '{
                  brAddr:   in_br_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                  nextAddr: in_next_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                  isCondBr: in_is_cond_br[i]
               };
            end else begin
               w_drop_cnt = w_drop_cnt + LCW'(1);
            end
         end
      end
   end

   assign w_drop_sum = {1'b0, r_drop} + 17'(w_drop_cnt);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_val  <= '0;
         r_drop <= '0;
      end else begin
         r_val  <= w_val_n;
         r_ent  <= w_ent_n;
         r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
   end

endmodule
